mon_mem_engine: RTL
===================

// Module: mon_mem_engine
// PURPOSE
//  Parametrised UART-monitor memory engine: turns decoded monitor commands into D-RAM line writes, range dumps and
//  region fill. Sits between the UART command decoder/sender and the D-RAM port. Generalises bus width and send-beat
//  width, adds a handshaked multi-line dump FSM, programmable fill and command-collision error reporting.
// PARAMETERS
//  DBW       128  D-RAM line width, bits; multiple of 32; LANES=DBW/32 (localparam, power of 2, >=2)
//  SNDW      2    32-bit words per send beat; power of 2, divides LANES; snd_data width = 32*SNDW
//  FILL_LG2  12   log2 of fill region size in lines; region = lines 0 .. 2^FILL_LG2-1
// PORTS
//  clk        in   1        clock
//  rst_n      in   1        asynchronous active-low reset
//  cmd_data   in   32       decoder payload (address / data / pattern)
//  wadr_set   in   1        load write pointer <= cmd_data[31:2]
//  wdata_en   in   1        write cmd_data at pointer, pointer += 1
//  rstart_set in   1        load dump start word <= cmd_data[31:2]
//  rend_set   in   1        load dump end word (inclusive) and launch dump
//  rstop      in   1        abort dump
//  fill_start in   1        launch fill; cmd_data = pattern (see CONFIGURATION)
//  d_wadr     out  32       line-aligned write byte address
//  d_wdata    out  DBW      write data, 32-bit word replicated LANES times
//  d_wmask    out  DBW/8    byte mask, 1 = byte kept (not written)
//  d_wen      out  1        write strobe, 1 cycle
//  d_wresp    in   1        write completion pulse
//  d_radr     out  32       line-aligned read byte address
//  d_rstart   out  1        read request pulse
//  d_rdata    in   DBW      read line, valid with d_rvalid
//  d_rvalid   in   1        read data valid pulse
//  snd_start  out  1        send-beat request pulse
//  snd_data   out  32*SNDW  beat payload, lower word = lower address, stable until snd_done
//  snd_done   in   1        sender finished beat
//  dump_busy  out  1        dump FSM not IDLE
//  fill_busy  out  1        fill in progress
//  cmd_err    out  1        1-cycle pulse: command dropped due to collision
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; pointers, buffers, fill counter 0. Reset mid-op abandons all transfers.
//  Write: d_wen = wdata_en same cycle (combinational); d_wadr = {ptr[31:LG2(LANES)+2], 0}; d_wmask all 1 except
//   4 bytes of lane ptr[LG2(LANES)+1:2]. Pointer wraps 2^30-1 -> 0. wadr_set & wdata_en same cycle: write at old
//   pointer, then load new value.
//  Dump FSM: IDLE -> RREQ (d_rstart 1 cycle, d_radr = line of cur) -> RWAIT (until d_rvalid; capture line)
//   -> SEND (snd_start 1 cycle) -> SWAIT (until snd_done) -> cur += SNDW; cur > end: IDLE;
//   cur crossed line boundary: RREQ; else SEND.
//   cur starts at start word aligned down to SNDW. start > end: one beat still sent (beat containing start).
//   rstop in any state: IDLE next cycle; late d_rvalid/snd_done ignored. rend_set while busy: cmd_err, ignored.
//  Fill: fill_start when dump and fill idle -> fill_busy 1; per line n (0..2^FILL_LG2-1): d_wen 1 cycle, mask 0,
//   then wait d_wresp; after last wresp fill_busy 0 next cycle. Fill write port muxes over cmd write port.
//  Collisions: wdata_en or rend_set during fill, fill_start during dump or fill -> cmd_err, command dropped.
//   wdata_en coincident with fill's own d_wen cycle also dropped with cmd_err.
//  Arithmetic: cur/end compared as unsigned 31-bit (extra MSB) so end=2^30-1 terminates.
// CONFIGURATION
//  MON_FILL_PATTERN_EN defined: fill_start latches cmd_data as 32-bit pattern, replicated across line.
//  Not defined: cmd_data ignored on fill_start; fill writes all zeros.
// TESTING
//  wadr_set 0x1004, 3x wdata_en A/B/C (DBW=128) -> d_wadr 0x1000,0x1000,0x1000; masks ff0f,f0ff,0fff
//  rstart 0x0, rend 0x1C, ack each snd_done -> 2 d_rstart (0x0, 0x10), 4 beats words {1,0},{3,2},{5,4},{7,6}, IDLE
//  rstart 0xC, rend 0xC -> 1 d_rstart 0x0, 1 beat words {3,2}, dump_busy low 1 cycle after snd_done
//  rstop asserted in RWAIT, then d_rvalid -> no snd_start, dump_busy 0 next cycle
//  FILL_LG2=2, fill_start 0xDEADBEEF, wresp 3 cycles after each wen -> 4 writes to 0x0..0x30, mask 0,
//   data DEADBEEF x4 (macro on) / 0 (off); wdata_en mid-fill -> cmd_err pulse, no extra write
//  rst_n low mid-dump SWAIT -> all outputs 0, subsequent dump runs from new start cleanly

Source files
------------

// File: rtl/mon_mem_engine.sv
// UART-monitor memory engine: command writes, multi-line dump FSM and region fill.
// Optional MON_FILL_PATTERN_EN: fill writes a latched 32-bit pattern instead of zeros.
module mon_mem_engine #(
    parameter int DBW      = 128,
    parameter int SNDW     = 2,
    parameter int FILL_LG2 = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       cmd_data,
    input  logic              wadr_set,
    input  logic              wdata_en,
    input  logic              rstart_set,
    input  logic              rend_set,
    input  logic              rstop,
    input  logic              fill_start,
    output logic [31:0]       d_wadr,
    output logic [DBW-1:0]    d_wdata,
    output logic [DBW/8-1:0]  d_wmask,
    output logic              d_wen,
    input  logic              d_wresp,
    output logic [31:0]       d_radr,
    output logic              d_rstart,
    input  logic [DBW-1:0]    d_rdata,
    input  logic              d_rvalid,
    output logic              snd_start,
    output logic [32*SNDW-1:0] snd_data,
    input  logic              snd_done,
    output logic              dump_busy,
    output logic              fill_busy,
    output logic              cmd_err
);

    localparam int LANES = DBW / 32;
    localparam int LG    = $clog2(LANES);
    localparam int SW    = 32 * SNDW;

    typedef enum logic [2:0] {IDLE, RREQ, RWAIT, SEND, SWAIT} state_t;

    state_t              state, state_nx;
    logic [29:0]         ptr, start_w, end_w, cur;
    logic [DBW-1:0]      line;
    logic [FILL_LG2-1:0] fcnt;
    logic                fill_q, fill_wait, err;
    logic [31:0]         pat;
    logic                dump_idle, cmd_wr, fill_wr, launch, fill_go, snd_phase;
    logic [30:0]         cur_nx;

    assign dump_idle = (state == IDLE);
    assign cmd_wr    = wdata_en & ~fill_q;
    assign fill_wr   = fill_q & ~fill_wait;
    assign launch    = rend_set & dump_idle & ~fill_q;
    assign fill_go   = fill_start & dump_idle & ~fill_q;
    // Extra MSB so an end word of 2^30-1 still terminates.
    assign cur_nx    = {1'b0, cur} + 31'(SNDW);
    assign snd_phase = (state == SEND) || (state == SWAIT);

    assign dump_busy = ~dump_idle;
    assign fill_busy = fill_q;
    assign cmd_err   = err;
    assign d_radr    = d_rstart ? {cur[29:LG], {(LG+2){1'b0}}} : 32'h0;
    assign snd_data  = snd_phase ? SW'(line >> {cur[LG-1:0], 5'b0}) : '0;

`ifdef MON_FILL_PATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       pat <= '0;
        else if (fill_go) pat <= cmd_data;
    end
`else
    assign pat = '0;
`endif

    // Fill owns the write port while busy; command writes are dropped then.
    always_comb begin
        d_wen   = 1'b0;
        d_wadr  = '0;
        d_wdata = '0;
        d_wmask = '0;
        if (fill_wr) begin
            d_wen   = 1'b1;
            d_wadr  = 32'(fcnt) << (LG + 2);
            d_wdata = {LANES{pat}};
        end else if (cmd_wr) begin
            d_wen   = 1'b1;
            d_wadr  = {ptr[29:LG], {(LG+2){1'b0}}};
            d_wdata = {LANES{cmd_data}};
            d_wmask = '1;
            d_wmask[{ptr[LG-1:0], 2'b00} +: 4] = 4'h0;
        end
    end

    always_comb begin
        state_nx  = state;
        d_rstart  = 1'b0;
        snd_start = 1'b0;
        unique case (state)
            IDLE:  if (launch) state_nx = RREQ;
            RREQ: begin
                d_rstart = 1'b1;
                state_nx = RWAIT;
            end
            RWAIT: if (d_rvalid) state_nx = SEND;
            SEND: begin
                snd_start = 1'b1;
                state_nx  = SWAIT;
            end
            SWAIT: begin
                if (snd_done) begin
                    if (cur_nx > {1'b0, end_w})  state_nx = IDLE;
                    else if (cur_nx[LG-1:0] == '0) state_nx = RREQ;
                    else                           state_nx = SEND;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (rstop) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            start_w   <= '0;
            end_w     <= '0;
            cur       <= '0;
            line      <= '0;
            fcnt      <= '0;
            fill_q    <= 1'b0;
            fill_wait <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (wadr_set)    ptr <= cmd_data[31:2];
            else if (cmd_wr) ptr <= ptr + 30'd1;
            if (rstart_set) start_w <= cmd_data[31:2];
            if (launch && !rstop) begin
                end_w <= cmd_data[31:2];
                cur   <= start_w & ~30'(SNDW - 1);
            end
            if (state == RWAIT && d_rvalid) line <= d_rdata;
            if (state == SWAIT && snd_done) cur <= cur_nx[29:0];
            err <= (wdata_en & fill_q)
                 | (rend_set & (~dump_idle | fill_q))
                 | (fill_start & (~dump_idle | fill_q));
            if (fill_go) begin
                fill_q    <= 1'b1;
                fill_wait <= 1'b0;
                fcnt      <= '0;
            end else if (fill_q) begin
                if (fill_wr) begin
                    fill_wait <= 1'b1;
                end else if (d_wresp) begin
                    fill_wait <= 1'b0;
                    if (fcnt == '1) fill_q <= 1'b0;
                    else            fcnt   <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule
